dmem_mmio: RTL

Data-side memory subsystem that sits directly downstream of the single-cycle MIPS core's data port, consuming `WE`, `address_to_mem` and `data_to_mem`, and producing `data_from_mem`. It contains:
- a word-addressed data RAM;
- a free-running, writable cycle counter;
- a store-to-stream output FIFO drained through a valid/ready handshake.

Reads are combinational so the core completes a `lw` in its single cycle. Writes take effect on the rising clock edge.

---
 rtl/dmem_mmio.sv | 114 +++++++++++
 1 files changed

// File: rtl/dmem_mmio.sv
// Data-side memory for the single-cycle core: word RAM, a writable cycle counter,
// and a store-to-stream FIFO drained through a valid/ready handshake.
module dmem_mmio #(
    parameter int RAM_WORDS  = 64,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        WE,
    input  logic [31:0] address_to_mem,
    input  logic [31:0] data_to_mem,
    output logic [31:0] data_from_mem,
    output logic [31:0] out_data,
    output logic        out_valid,
    input  logic        out_ready
);

    localparam int AW = $clog2(RAM_WORDS);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [31:0] A_CYCLE  = 32'hFFFF_0000;
    localparam logic [31:0] A_STATUS = 32'hFFFF_0004;
    localparam logic [31:0] A_TXDATA = 32'hFFFF_0008;
    localparam logic [31:0] RAM_BYTES = 32'(RAM_WORDS * 4);

    logic [31:0]   r_ram  [RAM_WORDS];
    logic [31:0]   r_fifo [FIFO_DEPTH];
    logic [31:0]   r_cycle;
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_wr_ptr;
    logic [PW:0]   r_count;
    logic          r_ovf;

    logic          w_ram_sel;
    logic          w_cyc_sel;
    logic          w_stat_sel;
    logic          w_tx_sel;
    logic [AW-1:0] w_ram_idx;
    logic          w_empty;
    logic          w_full;
    logic          w_pop;
    logic          w_push_req;
    logic          w_push_ok;
    logic [31:0]   w_status;

    assign w_ram_sel  = (address_to_mem < RAM_BYTES);
    assign w_cyc_sel  = (address_to_mem == A_CYCLE);
    assign w_stat_sel = (address_to_mem == A_STATUS);
    assign w_tx_sel   = (address_to_mem == A_TXDATA);
    assign w_ram_idx  = address_to_mem[AW+1:2];

    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == (PW+1)'(FIFO_DEPTH));
    assign out_valid  = !w_empty;
    assign out_data   = r_fifo[r_rd_ptr];
    assign w_pop      = out_valid && out_ready;
    assign w_push_req = WE && w_tx_sel;
    // A pop on the same edge frees the slot, so a full FIFO can still take a push.
    assign w_push_ok  = w_push_req && (!w_full || w_pop);

    assign w_status   = {24'd0, r_ovf, 5'(r_count), w_full, w_empty};

    always_comb begin
        data_from_mem = 32'd0;
        if (w_ram_sel)
            data_from_mem = r_ram[w_ram_idx];
        else if (w_cyc_sel)
            data_from_mem = r_cycle;
        else if (w_stat_sel)
            data_from_mem = w_status;
    end

    always_ff @(posedge clk) begin
        if (WE && w_ram_sel)
            r_ram[w_ram_idx] <= data_to_mem;
    end

    always_ff @(posedge clk) begin
        if (w_push_ok)
            r_fifo[r_wr_ptr] <= data_to_mem;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_cycle <= 32'd0;
        else if (WE && w_cyc_sel)
            r_cycle <= data_to_mem;
        else
            r_cycle <= r_cycle + 32'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + PW'(1);
            if (w_push_ok)
                r_wr_ptr <= r_wr_ptr + PW'(1);
            case ({w_push_ok, w_pop})
                2'b10:   r_count <= r_count + (PW+1)'(1);
                2'b01:   r_count <= r_count - (PW+1)'(1);
                default: r_count <= r_count;
            endcase
            if (w_push_req && !w_push_ok)
                r_ovf <= 1'b1;
            else if (WE && w_stat_sel)
                r_ovf <= 1'b0;
        end
    end

endmodule
